// File: rtl/vga_rx_pkg.sv
// Shared types and constants for the VGA sync receiver: FSM states, register map,
// CRC-16-CCITT constants and nominal 640x480 timing values.
package vga_rx_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNCED = 2'd1,
    LOCKED = 2'd2
  } rx_state_e;

  localparam logic [2:0] REG_LINE_LEN    = 3'd0;
  localparam logic [2:0] REG_ACT_W       = 3'd1;
  localparam logic [2:0] REG_ACT_LINES   = 3'd2;
  localparam logic [2:0] REG_TOTAL_LINES = 3'd3;
  localparam logic [2:0] REG_FRAME_CNT   = 3'd4;
  localparam logic [2:0] REG_STATUS      = 3'd5;
  localparam logic [2:0] REG_CRC         = 3'd6;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  localparam int EXP_LINE_LEN    = 800;
  localparam int EXP_ACT_W       = 640;
  localparam int EXP_ACT_LINES   = 480;
  localparam int EXP_TOTAL_LINES = 525;

endpackage

// File: rtl/vga_rx_crc16.sv
// One CRC-16-CCITT step over a 24-bit {r,g,b} word, MSB first.
// Present only when VGA_RX_CRC_EN is defined.
`ifdef VGA_RX_CRC_EN
module vga_rx_crc16
  import vga_rx_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [23:0] data,
  output logic [15:0] crc_out
);
  always_comb begin
    crc_out = crc_in;
    for (int i = 23; i >= 0; i--)
      crc_out = {crc_out[14:0], 1'b0} ^ ((crc_out[15] ^ data[i]) ? CRC_POLY : 16'h0000);
  end
endmodule
`endif

// File: rtl/vga_sync_receiver.sv
// VGA link receiver: recovers line/frame timing, checks stability, reports over Avalon-MM.
// Define VGA_RX_CRC_EN to add a per-frame CRC-16 of active pixel colour on register 6.
module vga_sync_receiver
  import vga_rx_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vga_clk,
  input  logic             vga_hs,
  input  logic             vga_vs,
  input  logic             vga_blank_n,
  input  logic [7:0]       vga_r,
  input  logic [7:0]       vga_g,
  input  logic [7:0]       vga_b,
  input  logic             chipselect,
  input  logic             read,
  input  logic [2:0]       address,
  output logic [CNT_W-1:0] readdata,
  output logic             locked
);
  localparam int SW = $clog2(LOCK_FRAMES + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_MAX = '1;

  function automatic cnt_t sat_inc(cnt_t v, logic inc);
    return (inc && v != CNT_MAX) ? v + cnt_t'(1) : v;
  endfunction

  logic vga_clk_q, hs_q, vs_q;
  logic pix_en, hs_fall, vs_fall;

  assign pix_en  = vga_clk & ~vga_clk_q;
  assign hs_fall = pix_en & hs_q & ~vga_hs;
  assign vs_fall = pix_en & vs_q & ~vga_vs;

  // Sync history starts low so a bus already in a sync pulse after reset gives no false edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_clk_q <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
    end else begin
      vga_clk_q <= vga_clk;
      if (pix_en) begin
        hs_q <= vga_hs;
        vs_q <= vga_vs;
      end
    end
  end

  cnt_t pix_cnt, act_cnt, line_cnt, act_line_cnt;
  cnt_t line_len, act_w, act_lines, total_lines, frame_cnt;
  cnt_t f_line_len, f_act_w;
  logic dirty, err;

  cnt_t line_act, line_len_nxt, act_w_nxt, act_lines_nxt, total_nxt;
  logic dirty_now, frame_ok, timeout;

  // Next values fold the line ending on this tick into the frame figures, so a
  // coincident hs/vs fall counts that line in the frame just closed.
  always_comb begin
    line_act      = sat_inc(act_cnt, vga_blank_n);
    line_len_nxt  = hs_fall ? sat_inc(pix_cnt, 1'b1) : line_len;
    act_w_nxt     = (hs_fall && line_act != '0) ? line_act : act_w;
    act_lines_nxt = sat_inc(act_line_cnt, hs_fall && line_act != '0);
    total_nxt     = sat_inc(line_cnt, hs_fall);
    dirty_now     = dirty | (hs_fall & (line_len_nxt != line_len));
    frame_ok      = !dirty_now && line_len_nxt == f_line_len && act_w_nxt == f_act_w &&
                    act_lines_nxt == act_lines && total_nxt == total_lines;
    timeout       = pix_en & ~hs_fall & (pix_cnt == CNT_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_cnt      <= '0;
      act_cnt      <= '0;
      line_cnt     <= '0;
      act_line_cnt <= '0;
      line_len     <= '0;
      act_w        <= '0;
      act_lines    <= '0;
      total_lines  <= '0;
      frame_cnt    <= '0;
      f_line_len   <= '0;
      f_act_w      <= '0;
      dirty        <= 1'b0;
    end else if (pix_en) begin
      if (hs_fall) begin
        pix_cnt  <= '0;
        act_cnt  <= '0;
        line_len <= line_len_nxt;
        act_w    <= act_w_nxt;
      end else begin
        pix_cnt <= sat_inc(pix_cnt, 1'b1);
        act_cnt <= line_act;
      end
      if (vs_fall) begin
        line_cnt     <= '0;
        act_line_cnt <= '0;
        act_lines    <= act_lines_nxt;
        total_lines  <= total_nxt;
        f_line_len   <= line_len_nxt;
        f_act_w      <= act_w_nxt;
        frame_cnt    <= frame_cnt + cnt_t'(1);
        dirty        <= 1'b0;
      end else begin
        line_cnt     <= total_nxt;
        act_line_cnt <= act_lines_nxt;
        dirty        <= dirty_now;
      end
    end
  end

  rx_state_e     state, state_d;
  logic [SW-1:0] streak, streak_d;
  logic          err_set;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= SEARCH;
      streak <= '0;
    end else begin
      state  <= state_d;
      streak <= streak_d;
    end
  end

  // streak == 0 means the next full frame only sets the baseline; a line-length change
  // anywhere inside a frame disqualifies it.
  always_comb begin
    state_d  = state;
    streak_d = streak;
    err_set  = 1'b0;
    if (vs_fall) begin
      unique case (state)
        SEARCH: begin
          state_d  = SYNCED;
          streak_d = '0;
        end
        SYNCED: begin
          if (streak == '0) streak_d = dirty_now ? '0 : SW'(1);
          else              streak_d = frame_ok ? streak + SW'(1) : '0;
          if (streak_d >= SW'(LOCK_FRAMES)) state_d = LOCKED;
        end
        LOCKED: begin
          if (!frame_ok) begin
            state_d  = SYNCED;
            streak_d = '0;
            err_set  = 1'b1;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    if (timeout) begin
      state_d  = SEARCH;
      streak_d = '0;
      err_set  = 1'b1;
    end
  end

  assign locked = (state == LOCKED);

  cnt_t crc_rd;
`ifdef VGA_RX_CRC_EN
  logic [15:0] crc_acc, crc_reg, crc_step;

  vga_rx_crc16 u_crc (
    .crc_in (crc_acc),
    .data   ({vga_r, vga_g, vga_b}),
    .crc_out(crc_step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_acc <= CRC_INIT;
      crc_reg <= '0;
    end else if (pix_en) begin
      if (vs_fall) begin
        crc_reg <= vga_blank_n ? crc_step : crc_acc;
        crc_acc <= CRC_INIT;
      end else if (vga_blank_n) begin
        crc_acc <= crc_step;
      end
    end
  end

  assign crc_rd = CNT_W'(crc_reg);
`else
  logic unused_rgb;
  assign unused_rgb = ^{vga_r, vga_g, vga_b};
  assign crc_rd     = '0;
`endif

  logic rd_en;
  cnt_t rd_mux;
  assign rd_en = chipselect & read;

  always_comb begin
    rd_mux = '0;
    case (address)
      REG_LINE_LEN:    rd_mux = line_len;
      REG_ACT_W:       rd_mux = act_w;
      REG_ACT_LINES:   rd_mux = act_lines;
      REG_TOTAL_LINES: rd_mux = total_lines;
      REG_FRAME_CNT:   rd_mux = frame_cnt;
      REG_STATUS:      rd_mux = CNT_W'({err, locked});
      REG_CRC:         rd_mux = crc_rd;
      default:         rd_mux = '0;
    endcase
  end

  // A status read clears err, but a new error in the same clock keeps it set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err      <= 1'b0;
      readdata <= '0;
    end else begin
      err <= (err & ~(rd_en && address == REG_STATUS)) | err_set;
      if (rd_en) readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver: scaled-down VGA timings, expectations from the timing parameters.
module tb_vga_sync_receiver;
  import vga_rx_pkg::*;

  localparam int CNT_W = 10;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 0, reset = 1;
  logic vga_clk = 0, vga_hs = 1, vga_vs = 1, vga_blank_n = 0;
  logic [7:0] vga_r = 0, vga_g = 0, vga_b = 0;
  logic chipselect = 0, read = 0;
  logic [2:0] address = 0;
  logic [CNT_W-1:0] readdata;
  logic locked;

  int n_tests = 0, n_fail = 0;
  int ht, ha, vt, va;
  bit vs_on_hs;
  logic [23:0] col;

  typedef struct {
    int ht, ha, vt, va;
    bit vs_on_hs;
    int frames;
    logic [23:0] col;
    int e_len, e_aw, e_al, e_tl, e_lock;
  } vec_t;
  vec_t tbl[5];

  always #10 clk = ~clk;

  vga_sync_receiver #(.CNT_W(CNT_W), .LOCK_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .chipselect(chipselect), .read(read), .address(address),
    .readdata(readdata), .locked(locked)
  );

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

`ifdef VGA_RX_CRC_EN
  function automatic int model_crc(int npix, logic [23:0] c);
    logic [15:0] s;
    s = 16'hFFFF;
    for (int k = 0; k < npix; k++)
      for (int i = 23; i >= 0; i--)
        s = (s[15] ^ c[i]) ? ({s[14:0], 1'b0} ^ 16'h1021) : {s[14:0], 1'b0};
    return int'(s[CNT_W-1:0]);
  endfunction
`endif

  task automatic pix(logic hs, logic vs, logic bn, logic [23:0] c);
    @(negedge clk);
    vga_clk = 1; vga_hs = hs; vga_vs = vs; vga_blank_n = bn;
    {vga_r, vga_g, vga_b} = c;
    @(negedge clk);
    vga_clk = 0;
  endtask

  task automatic gen_line(int l, int extra);
    int vs0, pos;
    logic hs, vs, bn;
    vs0 = (va + 1) * ht + (vs_on_hs ? ha + 2 : 0);
    for (int p = 0; p < ht + extra; p++) begin
      pos = l * ht + ((p < ht) ? p : ht - 1);
      hs  = !(p >= ha + 2 && p < ha + 5);
      vs  = !(pos >= vs0 && pos < vs0 + 2 * ht);
      bn  = (l < va) && (p < ha);
      pix(hs, vs, bn, bn ? col : 24'h0);
    end
  endtask

  task automatic gen_frames(int n, int stretch_f);
    for (int f = 0; f < n; f++)
      for (int l = 0; l < vt; l++)
        gen_line(l, (f == stretch_f && l == 2) ? 4 : 0);
  endtask

  task automatic gen_lines(int n);
    for (int l = 0; l < n; l++) gen_line(l, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; vga_clk = 0; vga_hs = 1; vga_vs = 1; vga_blank_n = 0;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  task automatic rd(int a, output int d);
    @(negedge clk);
    chipselect = 1; read = 1; address = 3'(a);
    @(negedge clk);
    chipselect = 0; read = 0;
    d = int'(readdata);
  endtask

  task automatic set_std();
    ht = 40; ha = 32; vt = 12; va = 8; vs_on_hs = 0; col = 24'h000080;
  endtask

  task automatic check_all_zero(string tag);
    int d;
    for (int a = 0; a < 8; a++) begin
      rd(a, d);
      check($sformatf("%s.reg%0d", tag, a), d, 0);
    end
    check($sformatf("%s.locked", tag), int'(locked), 0);
  endtask

  initial begin
    int d, e_crc;
    repeat (3) @(negedge clk);
    reset = 0;
    check_all_zero("reset");

    tbl[0] = '{40, 32, 12, 8, 1'b0, 3, 24'h000080, 40, 32, 8, 12, 1};
    tbl[1] = '{40, 32, 12, 8, 1'b0, 2, 24'h123456, 40, 32, 8, 12, 0};
    tbl[2] = '{40, 32, 12, 8, 1'b1, 4, 24'h000080, 40, 32, 8, 12, 1};
    for (int i = 3; i < 5; i++) begin
      tbl[i].ha       = int'($urandom_range(30, 6));
      tbl[i].ht       = tbl[i].ha + int'($urandom_range(14, 6));
      tbl[i].va       = int'($urandom_range(8, 4));
      tbl[i].vt       = tbl[i].va + int'($urandom_range(7, 4));
      tbl[i].vs_on_hs = 1'($urandom_range(1, 0));
      tbl[i].frames   = int'($urandom_range(5, 2));
      tbl[i].col      = 24'($urandom);
      tbl[i].e_len    = tbl[i].ht;
      tbl[i].e_aw     = tbl[i].ha;
      tbl[i].e_al     = tbl[i].va;
      tbl[i].e_tl     = tbl[i].vt;
      tbl[i].e_lock   = (tbl[i].frames >= 3) ? 1 : 0;
    end

    for (int i = 0; i < 5; i++) begin
      ht = tbl[i].ht; ha = tbl[i].ha; vt = tbl[i].vt; va = tbl[i].va;
      vs_on_hs = tbl[i].vs_on_hs; col = tbl[i].col;
      do_reset();
      gen_frames(tbl[i].frames, -1);
      rd(REG_LINE_LEN, d);    check($sformatf("v%0d.line_len", i), d, tbl[i].e_len);
      rd(REG_ACT_W, d);       check($sformatf("v%0d.act_w", i), d, tbl[i].e_aw);
      rd(REG_ACT_LINES, d);   check($sformatf("v%0d.act_lines", i), d, tbl[i].e_al);
      rd(REG_TOTAL_LINES, d); check($sformatf("v%0d.total_lines", i), d, tbl[i].e_tl);
      rd(REG_FRAME_CNT, d);   check($sformatf("v%0d.frame_cnt", i), d, tbl[i].frames);
      check($sformatf("v%0d.locked", i), int'(locked), tbl[i].e_lock);
      rd(REG_STATUS, d);      check($sformatf("v%0d.status", i), d, tbl[i].e_lock);
`ifdef VGA_RX_CRC_EN
      e_crc = model_crc(va * ha, col);
`else
      e_crc = 0;
`endif
      rd(REG_CRC, d);         check($sformatf("v%0d.crc", i), d, e_crc);
      rd(7, d);               check($sformatf("v%0d.reg7", i), d, 0);
    end

    // Stretched line while locked: unlock, err once, relock after two clean frames.
    set_std();
    do_reset();
    gen_frames(3, -1);
    check("stretch.pre_locked", int'(locked), 1);
    gen_frames(1, 0);
    check("stretch.unlocked", int'(locked), 0);
    rd(REG_STATUS, d); check("stretch.status1", d, 2);
    rd(REG_STATUS, d); check("stretch.status2", d, 0);
    gen_frames(1, -1);
    check("stretch.clean1", int'(locked), 0);
    gen_frames(1, -1);
    check("stretch.relock", int'(locked), 1);
    rd(REG_FRAME_CNT, d); check("stretch.frame_cnt", d, 6);

    // hs silent for more than 2^CNT_W ticks.
    do_reset();
    gen_frames(3, -1);
    check("timeout.pre_locked", int'(locked), 1);
    for (int k = 0; k < CMAX + 8; k++) pix(1'b1, 1'b1, 1'b0, 24'h0);
    check("timeout.locked", int'(locked), 0);
    rd(REG_STATUS, d); check("timeout.status", d, 2);
    gen_lines(1);
    rd(REG_LINE_LEN, d); check("timeout.line_len_sat", d, CMAX);
    gen_frames(2, -1);
    check("timeout.search_2f", int'(locked), 0);
    gen_frames(1, -1);
    check("timeout.relock", int'(locked), 1);

    // Reset in the middle of a frame.
    do_reset();
    gen_frames(3, -1);
    gen_lines(5);
    do_reset();
    check_all_zero("midreset");
    gen_frames(2, -1);
    check("midreset.2f", int'(locked), 0);
    gen_frames(1, -1);
    check("midreset.relock", int'(locked), 1);
    rd(REG_FRAME_CNT, d); check("midreset.frame_cnt", d, 3);
    rd(REG_TOTAL_LINES, d); check("midreset.total", d, 12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
